// File: rtl/dmem_pkg.sv
// Shared defaults and types for the data memory block.
// The top-level design is compiled with or without the optional DMEM_WRITE_BYPASS_EN feature.
package dmem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int WORD_IDX_W = ADDR_W_DEF - 2;
    localparam int DEPTH_DEF  = 2 ** WORD_IDX_W;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    // Word index of a byte address; the two low byte-lane bits are dropped.
    function automatic word_idx_t word_index(input logic [ADDR_W_DEF-1:0] byte_addr);
        return byte_addr[ADDR_W_DEF-1:2];
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide storage array: synchronous write through one port, plus an independent read address.
// The contents are never reset.
module dmem_ram #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Store one word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    // The owner registers this value, which makes it a read-first access.
    assign dout = mem_r[raddr];

endmodule

// File: rtl/data_memory.sv
// CPU data memory with a firmware-upgrade write port and a registered read output.
// Optional DMEM_WRITE_BYPASS_EN forwards same-cycle CPU write data to the read output.
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWrite_i,
    input  logic              IoWrite2_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_m_i,
    output logic [DATA_W-1:0] rdata_m_o,
    input  logic              upg_rst_i,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_addr_i,
    input  logic [DATA_W-1:0] upg_data_i,
    input  logic              upg_done_i
);

    localparam int IDX_W = ADDR_W - 2;

    logic              kick_off_s;
    logic              cpu_we_s;
    logic              we_s;
    logic [IDX_W-1:0]  waddr_s;
    logic [IDX_W-1:0]  raddr_s;
    logic [DATA_W-1:0] din_s;
    logic [DATA_W-1:0] ram_dout_s;
    logic [DATA_W-1:0] next_rdata_s;
    logic [DATA_W-1:0] rdata_r;
    logic              unused_lane_bits_s;

    assign kick_off_s         = upg_rst_i | upg_done_i;
    assign raddr_s            = addr_i[ADDR_W-1:2];
    assign unused_lane_bits_s = ^{addr_i[1:0], upg_addr_i[1:0]};

    // Write-port mux: the mode picks the CPU or the upgrade source; nothing is written during reset.
    always_comb begin
        cpu_we_s = 1'b0;
        we_s     = 1'b0;
        waddr_s  = '0;
        din_s    = '0;
        if (kick_off_s) begin
            cpu_we_s = MemWrite_i & ~IoWrite2_i;
            we_s     = cpu_we_s & rst_n;
            waddr_s  = addr_i[ADDR_W-1:2];
            din_s    = wdata_m_i;
        end else begin
            cpu_we_s = 1'b0;
            we_s     = upg_wen_i & rst_n;
            waddr_s  = upg_addr_i[ADDR_W-1:2];
            din_s    = upg_data_i;
        end
    end

    dmem_ram #(
        .AW (IDX_W),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .addr  (waddr_s),
        .din   (din_s),
        .raddr (raddr_s),
        .dout  (ram_dout_s)
    );

    // Select the value captured by the output register: old contents, or forwarded CPU write data.
    always_comb begin
        next_rdata_s = ram_dout_s;
`ifdef DMEM_WRITE_BYPASS_EN
        if (cpu_we_s && (waddr_s == raddr_s)) begin
            next_rdata_s = wdata_m_i;
        end else begin
            next_rdata_s = ram_dout_s;
        end
`else
        next_rdata_s = ram_dout_s;
`endif
    end

    // Output register; clears asynchronously and holds zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else begin
            rdata_r <= next_rdata_s;
        end
    end

    assign rdata_m_o = rdata_r;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a word-array model predicts each read,
// and a monitor compares the registered output one cycle later.
module tb_data_memory;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          MemWrite_i;
    logic          IoWrite2_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_m_i;
    logic [DW-1:0] rdata_m_o;
    logic          upg_rst_i;
    logic          upg_wen_i;
    logic [AW-1:0] upg_addr_i;
    logic [DW-1:0] upg_data_i;
    logic          upg_done_i;

    typedef struct {
        logic [DW-1:0] data;
        string         tag;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model [0:4095];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    data_memory dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWrite_i (MemWrite_i),
        .IoWrite2_i (IoWrite2_i),
        .addr_i     (addr_i),
        .wdata_m_i  (wdata_m_i),
        .rdata_m_o  (rdata_m_o),
        .upg_rst_i  (upg_rst_i),
        .upg_wen_i  (upg_wen_i),
        .upg_addr_i (upg_addr_i),
        .upg_data_i (upg_data_i),
        .upg_done_i (upg_done_i)
    );

    // Drive one cycle of inputs at a falling edge, predict the read, update the model,
    // then wait for the next falling edge.
    task automatic cyc(input logic memw, input logic io, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic ur, input logic uwen,
                       input logic [AW-1:0] ua, input logic [DW-1:0] ud,
                       input logic done, input bit chk, input string tag);
        exp_t e;
        bit   cpu_mode;
        int   ridx;
        int   widx;
        int   uidx;
        MemWrite_i = memw;
        IoWrite2_i = io;
        addr_i     = a;
        wdata_m_i  = wd;
        upg_rst_i  = ur;
        upg_wen_i  = uwen;
        upg_addr_i = ua;
        upg_data_i = ud;
        upg_done_i = done;
        cpu_mode = (ur == 1'b1) || (done == 1'b1);
        ridx = int'(a) / 4;
        widx = int'(a) / 4;
        uidx = int'(ua) / 4;
        e.data = model[ridx];
        e.tag  = tag;
        if (cpu_mode && memw && !io) begin
`ifdef DMEM_WRITE_BYPASS_EN
            if (widx == ridx) e.data = wd;
`endif
            model[widx] = wd;
        end
        if (!cpu_mode && uwen) begin
            model[uidx] = ud;
        end
        if (chk) sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        cyc(1'b1, 1'b0, a, d, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, tag);
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a, input string tag);
        cyc(1'b0, 1'b0, a, 32'h0, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, tag);
    endtask

    task automatic check_now(input logic [DW-1:0] want, input string tag);
        checks++;
        if (rdata_m_o !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, rdata_m_o, want);
        end
    endtask

    // Monitor: one expected entry per scored cycle, compared just after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rdata_m_o !== e.data) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h", e.tag, rdata_m_o, e.data);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] rnd;
        int            wait_cnt;
        rst_n = 1'b0;
        MemWrite_i = 1'b0; IoWrite2_i = 1'b0; addr_i = '0; wdata_m_i = '0;
        upg_rst_i = 1'b1; upg_wen_i = 1'b0; upg_addr_i = '0; upg_data_i = '0; upg_done_i = 1'b0;
        for (int i = 0; i < 4096; i++) model[i] = 32'h0;
        repeat (3) @(negedge clk);
        check_now(32'h0, "reset_state");
        rst_n = 1'b1;

        // Bring the exercised region to a known state through the upgrade port.
        for (int i = 0; i < 64; i++) begin
            rnd = $urandom;
            cyc(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, 14'(i * 4), rnd, 1'b0, 1'b0, "preload");
        end

        cpu_wr(14'h0004, 32'h0000_0010, "r30_wr");
        cpu_rd(14'h0004, "r30_rd");
        cpu_rd(14'h0007, "lane_bits_ignored");
        cyc(1'b1, 1'b1, 14'h0008, 32'hDEAD_BEEF, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, "r31_io_wr");
        cpu_rd(14'h0008, "r31_rd");
        cyc(1'b0, 1'b0, 14'h000C, 32'h0, 1'b1, 1'b1, 14'h000C, 32'h55, 1'b0, 1'b1, "r33_upg_ign");
        cpu_rd(14'h000C, "r33_rd");
        cpu_wr(14'h0010, 32'h0000_0001, "r34_init");
        cpu_wr(14'h0010, 32'hA5A5_A5A5, "r34_same_cycle");
        cpu_rd(14'h0010, "r34_after");

        // Reset in the middle of traffic: output clears at once, memory is untouched.
        rst_n = 1'b0;
        #1;
        check_now(32'h0, "r35_async_clear");
        MemWrite_i = 1'b1; IoWrite2_i = 1'b0; addr_i = 14'h0004; wdata_m_i = 32'hFFFF_FFFF;
        upg_rst_i = 1'b0; upg_wen_i = 1'b1; upg_addr_i = 14'h0004; upg_data_i = 32'hEEEE_EEEE;
        @(posedge clk);
        #1;
        check_now(32'h0, "r35_held");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_rd(14'h0004, "r35_after_reset");

        // Upgrade download with a competing CPU write, then completion and read-back.
        cyc(1'b1, 1'b0, 14'h0000, 32'hBAD0_BAD0, 1'b0, 1'b1, 14'h0000, 32'h10, 1'b0, 1'b1, "r32_u0");
        cyc(1'b1, 1'b0, 14'h0000, 32'hBAD1_BAD1, 1'b0, 1'b1, 14'h0004, 32'h20, 1'b0, 1'b1, "r32_u1");
        cyc(1'b1, 1'b0, 14'h0000, 32'hBAD2_BAD2, 1'b0, 1'b1, 14'h0008, 32'h30, 1'b0, 1'b1, "r32_u2");
        cyc(1'b0, 1'b0, 14'h0000, 32'h0, 1'b0, 1'b1, 14'h000C, 32'h77, 1'b1, 1'b1, "r32_rd0");
        cyc(1'b0, 1'b0, 14'h0004, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, "r32_rd1");
        cyc(1'b0, 1'b0, 14'h0008, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, "r32_rd2");
        cpu_rd(14'h000C, "r32_rd3");

        // Random mixed traffic over a small window so that collisions and mode flips are frequent.
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                14'($urandom_range(0, 63)), 32'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                14'($urandom_range(0, 63)), 32'($urandom),
                1'($urandom_range(0, 3) == 0), 1'b1, "random");
        end

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 5) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
